// File: rtl/fold_sig_accum.sv
// Frame signature accumulator: rotate-XOR over folded words with saturating beat count.
// Optional FOLD_SIG_PARITY_EN drives sig_par as the parity of sig; otherwise sig_par is 0.
module fold_sig_accum #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      aa,
    input  logic [15:0]      bb,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      sig,
    output logic [CNT_W-1:0] beat_cnt,
    output logic             cnt_ovf,
    output logic             sig_par
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [15:0]      sig_q, sig_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             accept;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sig_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) state_d = in_last ? HOLD : ACCUM;
            end
            ACCUM: begin
                if (accept && in_last) state_d = HOLD;
            end
            HOLD: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q != HOLD);
        out_valid = (state_q == HOLD);
    end

    assign accept = in_valid & in_ready;

    // A beat in IDLE starts a fresh frame regardless of the previous result.
    always_comb begin
        sig_d = sig_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (accept) begin
            if (state_q == IDLE) begin
                sig_d = aa ^ bb;
                cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
                ovf_d = 1'b0;
            end else begin
                sig_d = {sig_q[14:0], sig_q[15]} ^ aa ^ bb;
                if (cnt_q == CNT_MAX) ovf_d = 1'b1;
                else cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign sig      = sig_q;
    assign beat_cnt = cnt_q;
    assign cnt_ovf  = ovf_q;

`ifdef FOLD_SIG_PARITY_EN
    assign sig_par = ^sig_q;
`else
    assign sig_par = 1'b0;
`endif

endmodule

// File: tb/tb_fold_sig_accum.sv
// Randomized and directed bench for fold_sig_accum against a frame-level model.
// Parity expectations follow FOLD_SIG_PARITY_EN when the bench is built with it.
module tb_fold_sig_accum;

    localparam int CNT_W = 8;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      aa;
    logic [15:0]      bb;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      sig;
    logic [CNT_W-1:0] beat_cnt;
    logic             cnt_ovf;
    logic             sig_par;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    fold_sig_accum #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .aa(aa), .bb(bb), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .sig(sig), .beat_cnt(beat_cnt),
        .cnt_ovf(cnt_ovf), .sig_par(sig_par)
    );

    always #5 clk = ~clk;

    // Frame model: beats of the open frame, plus the last reported result.
    logic [15:0] frame_q[$];
    bit          holding = 1'b0;
    logic [15:0] res_sig = '0;
    int          res_n   = 0;

    function automatic logic [15:0] fold(input logic [15:0] q[$]);
        logic [15:0] s = '0;
        foreach (q[i]) s = {s[14:0], s[15]} ^ q[i];
        return s;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            frame_q.delete();
            holding = 1'b0;
            res_sig = '0;
            res_n   = 0;
        end else if (holding) begin
            if (out_ready) holding = 1'b0;
        end else if (in_valid) begin
            frame_q.push_back(aa ^ bb);
            if (in_last) begin
                res_sig = fold(frame_q);
                res_n   = frame_q.size();
                frame_q.delete();
                holding = 1'b1;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit par_of(input logic [15:0] s);
`ifdef FOLD_SIG_PARITY_EN
        return ^s;
`else
        return 1'b0;
`endif
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            logic [15:0] es;
            int          en;
            if (frame_q.size() != 0) begin
                es = fold(frame_q);
                en = frame_q.size();
            end else begin
                es = res_sig;
                en = res_n;
            end
            check("in_ready", int'(in_ready), int'(!holding));
            check("out_valid", int'(out_valid), int'(holding));
            check("sig", int'(sig), int'(es));
            check("beat_cnt", int'(beat_cnt), (en > MAXC) ? MAXC : en);
            check("cnt_ovf", int'(cnt_ovf), int'(en > MAXC));
            check("sig_par", int'(sig_par), int'(par_of(es)));
        end
    end

    task automatic beat(input logic [15:0] a, input logic [15:0] b,
                        input logic last);
        in_valid = 1'b1;
        aa       = a;
        bb       = b;
        in_last  = last;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        aa        = '0;
        bb        = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        rst_n  = 1'b1;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_sig", int'(sig), 0);
        check("rst_cnt", int'(beat_cnt), 0);
        @(negedge clk);

        // Single beat frame.
        beat(16'h1234, 16'h00FF, 1'b1);
        check("single_valid", int'(out_valid), 1);
        check("single_sig", int'(sig), 16'h12CB);
        check("single_cnt", int'(beat_cnt), 1);
`ifdef FOLD_SIG_PARITY_EN
        check("single_par", int'(sig_par), 1);
`else
        check("single_par", int'(sig_par), 0);
`endif
        release_result();

        // Two beat frame, then backpressure with a beat offered in HOLD.
        beat(16'h0001, 16'h0000, 1'b0);
        beat(16'h0000, 16'h0000, 1'b1);
        check("two_sig", int'(sig), 16'h0002);
        check("two_cnt", int'(beat_cnt), 2);
        in_valid = 1'b1;
        aa       = 16'h0A0A;
        bb       = 16'h5050;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_sig", int'(sig), 16'h0002);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_idle_valid", int'(out_valid), 0);
        check("bp_idle_ready", int'(in_ready), 1);
        check("bp_idle_sig", int'(sig), 16'h0002);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("bp_next_sig", int'(sig), 16'h5A5A);
        check("bp_next_valid", int'(out_valid), 1);
        release_result();

        // 256 zero beats saturate the counter.
        for (int i = 1; i <= 256; i++) beat(16'h0000, 16'h0000, i == 256);
        check("ovf_cnt", int'(beat_cnt), 255);
        check("ovf_flag", int'(cnt_ovf), 1);
        check("ovf_sig", int'(sig), 0);
        release_result();

        // Reset in the middle of a frame.
        beat(16'h1111, 16'h0203, 1'b0);
        beat(16'h8001, 16'h0000, 1'b0);
        beat(16'hBEEF, 16'h0042, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_sig", int'(sig), 0);
        check("mid_rst_cnt", int'(beat_cnt), 0);
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_ready", int'(in_ready), 1);
        beat(16'h00F0, 16'h000F, 1'b1);
        check("mid_rst_new_sig", int'(sig), 16'h00FF);
        release_result();

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            rst_n     = ($urandom_range(0, 199) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_last   = ($urandom_range(0, 7) == 0);
            aa        = 16'($urandom);
            bb        = 16'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
        end
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
